// File: rtl/player_move_rect.sv
// Player position tracker and sprite-box test feeding the player bitmap stage.
// Optional macro PLAYER_BLINK_EN blinks the frozen player; FREEZE_FRAMES=0 is unsupported.
module player_move_rect #(
  parameter int OBJECT_WIDTH_X = 32,
  parameter int OBJECT_HEIGHT_Y = 20,
  parameter int SCREEN_WIDTH = 640,
  parameter int FLOOR_Y = 440,
  parameter int START_X = 304,
  parameter int SPEED = 4,
  parameter int FREEZE_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        leftPress,
  input  logic        rightPress,
  input  logic        hit,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        frozen
);

  localparam int RIGHT_MAX = SCREEN_WIDTH - OBJECT_WIDTH_X;
  localparam int TOP_Y = FLOOR_Y - OBJECT_HEIGHT_Y;
  localparam int CW = $clog2(FREEZE_FRAMES + 1);

  typedef enum logic {
    WALK   = 1'b0,
    FROZEN = 1'b1
  } state_t;

  state_t          r_state;
  logic            r_frozen;
  logic [CW-1:0]   r_cnt;
  logic [10:0]     r_x;

  logic signed [11:0] w_left;
  logic [11:0]        w_right;
  logic [10:0]        w_x_next;
  logic [11:0]        w_px;
  logic [11:0]        w_py;
  logic [11:0]        w_x12;
  logic               w_inside;
  logic               w_blank;

  // 12-bit intermediates keep the left edge from wrapping and the right edge from overflowing
  assign w_left  = $signed({1'b0, r_x}) - $signed(12'(SPEED));
  assign w_right = {1'b0, r_x} + 12'(SPEED);

  always_comb begin
    w_x_next = r_x;
    if (leftPress && !rightPress) begin
      w_x_next = (w_left < 0) ? 11'd0 : w_left[10:0];
    end else if (rightPress && !leftPress) begin
      w_x_next = (w_right > 12'(RIGHT_MAX)) ? 11'(RIGHT_MAX) : w_right[10:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= WALK;
      r_frozen <= 1'b0;
      r_cnt    <= '0;
      r_x      <= 11'(START_X);
    end else begin
      case (r_state)
        WALK: begin
          if (hit) begin
            r_state  <= FROZEN;
            r_frozen <= 1'b1;
            r_cnt    <= CW'(FREEZE_FRAMES);
          end else if (startOfFrame) begin
            r_x <= w_x_next;
          end
        end
        FROZEN: begin
          // The releasing frame itself does not move; motion resumes next frame
          if (startOfFrame) begin
            if (r_cnt == CW'(1)) begin
              r_cnt    <= '0;
              r_state  <= WALK;
              r_frozen <= 1'b0;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
        end
      endcase
    end
  end

`ifdef PLAYER_BLINK_EN
  logic [7:0] r_frame;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame <= 8'd0;
    end else if (startOfFrame) begin
      r_frame <= r_frame + 8'd1;
    end
  end

  assign w_blank = r_frozen && r_frame[3];
`else
  assign w_blank = 1'b0;
`endif

  assign w_px  = {1'b0, pixelX};
  assign w_py  = {1'b0, pixelY};
  assign w_x12 = {1'b0, r_x};

  assign w_inside = (w_px >= w_x12) &&
                    (w_px < w_x12 + 12'(OBJECT_WIDTH_X)) &&
                    (w_py >= 12'(TOP_Y)) &&
                    (w_py < 12'(TOP_Y + OBJECT_HEIGHT_Y));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      InsideRectangle <= 1'b0;
      offsetX         <= 11'd0;
      offsetY         <= 11'd0;
    end else if (w_inside && !w_blank) begin
      InsideRectangle <= 1'b1;
      offsetX         <= pixelX - r_x;
      offsetY         <= pixelY - 11'(TOP_Y);
    end else begin
      InsideRectangle <= 1'b0;
      offsetX         <= 11'd0;
      offsetY         <= 11'd0;
    end
  end

  assign topLeftX = r_x;
  assign topLeftY = 11'(TOP_Y);
  assign frozen   = r_frozen;

endmodule

// File: tb/tb_player_move_rect.sv
// Self-checking bench for player_move_rect: vector table, corner sequences, random vs reference model.
module tb_player_move_rect;

  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame;
  logic        leftPress;
  logic        rightPress;
  logic        hit;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        InsideRectangle;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        frozen;

  player_move_rect dut (
    .clk(clk),
    .reset(reset),
    .startOfFrame(startOfFrame),
    .leftPress(leftPress),
    .rightPress(rightPress),
    .hit(hit),
    .pixelX(pixelX),
    .pixelY(pixelY),
    .offsetX(offsetX),
    .offsetY(offsetY),
    .InsideRectangle(InsideRectangle),
    .topLeftX(topLeftX),
    .topLeftY(topLeftY),
    .frozen(frozen)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position, frames of freeze remaining, frames since reset
  int m_x;
  int m_left;
  int m_frame;
  int e_in;
  int e_ox;
  int e_oy;

  typedef struct {
    logic s;
    logic l;
    logic r;
    logic h;
    int   px;
    int   py;
    int   ex;
    int   efz;
    int   ein;
    int   eox;
    int   eoy;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 304;
    m_left = 0;
    m_frame = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    startOfFrame = 1'b0;
    leftPress = 1'b0;
    rightPress = 1'b0;
    hit = 1'b0;
    pixelX = 11'd0;
    pixelY = 11'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Apply one clock of inputs; model expectations use the state before the edge
  task automatic cycle(input logic s, input logic l, input logic r, input logic h,
                       input int x, input int y);
    int blank;
    startOfFrame = s;
    leftPress = l;
    rightPress = r;
    hit = h;
    pixelX = 11'(x);
    pixelY = 11'(y);
    blank = 0;
`ifdef PLAYER_BLINK_EN
    blank = (m_left > 0 && ((m_frame >> 3) & 1) == 1) ? 1 : 0;
`endif
    e_in = (blank == 0 && x >= m_x && x < m_x + 32 && y >= 420 && y < 440) ? 1 : 0;
    e_ox = (e_in == 1) ? x - m_x : 0;
    e_oy = (e_in == 1) ? y - 420 : 0;
    if (m_left == 0) begin
      if (h) m_left = 60;
      else if (s) begin
        if (l && !r) m_x = (m_x - 4 < 0) ? 0 : m_x - 4;
        else if (r && !l) m_x = (m_x + 4 > 608) ? 608 : m_x + 4;
      end
    end else if (s) begin
      m_left--;
    end
    if (s) m_frame = (m_frame + 1) % 256;
    @(posedge clk);
    #1;
    startOfFrame = 1'b0;
    hit = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    check({tag, ".x"}, topLeftX, m_x);
    check({tag, ".frozen"}, frozen, (m_left > 0) ? 1 : 0);
    check({tag, ".inside"}, InsideRectangle, e_in);
    check({tag, ".offX"}, offsetX, e_ox);
    check({tag, ".offY"}, offsetY, e_oy);
  endtask

  initial begin
    int fc;
    int ex;
    int px;
    int py;
    logic bl;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 304, 420, 304, 0, 1, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 336, 420, 304, 0, 0, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 335, 439, 304, 0, 1, 31, 19};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 303, 430, 304, 0, 0, 0, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 310, 419, 304, 0, 0, 0, 0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 310, 425, 308, 0, 1, 6, 5};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 310, 425, 308, 0, 1, 2, 5};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 307, 425, 304, 0, 0, 0, 0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 304, 420, 304, 0, 1, 0, 0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 304, 0, 0, 0, 0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2047, 2047, 304, 0, 0, 0, 0};

    // Reset state
    do_reset();
    check("rst.x", topLeftX, 304);
    check("rst.y", topLeftY, 420);
    check("rst.frozen", frozen, 0);
    check("rst.inside", InsideRectangle, 0);
    check("rst.offX", offsetX, 0);
    check("rst.offY", offsetY, 0);

    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].s, tbl[i].l, tbl[i].r, tbl[i].h, tbl[i].px, tbl[i].py);
      $display("vec %0d: x=%0d frz=%0d in=%0d ox=%0d oy=%0d", i, topLeftX, frozen,
               InsideRectangle, offsetX, offsetY);
      check($sformatf("vec%0d.x", i), topLeftX, tbl[i].ex);
      check($sformatf("vec%0d.frozen", i), frozen, tbl[i].efz);
      check($sformatf("vec%0d.inside", i), InsideRectangle, tbl[i].ein);
      check($sformatf("vec%0d.offX", i), offsetX, tbl[i].eox);
      check($sformatf("vec%0d.offY", i), offsetY, tbl[i].eoy);
    end

    // Right saturation, then left down to zero with no wrap
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
      ex = (304 + 4 * i > 608) ? 608 : 304 + 4 * i;
      check("satR.x", topLeftX, ex);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    end
    $display("satR: final x=%0d", topLeftX);
    for (int i = 1; i <= 160; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
      ex = (608 - 4 * i < 0) ? 0 : 608 - 4 * i;
      check("satL.x", topLeftX, ex);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    end
    $display("satL: final x=%0d", topLeftX);

    // Both buttons held
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
      check("both.x", topLeftX, 304);
    end
    $display("both: x=%0d", topLeftX);

    // Freeze duration with a second hit mid-freeze
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    check("frz.enter", frozen, 1);
    for (int f = 1; f <= 60; f++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
      check("frz.x", topLeftX, 304);
      check("frz.frozen", frozen, (f < 60) ? 1 : 0);
      cycle(1'b0, 1'b0, 1'b1, (f == 30) ? 1'b1 : 1'b0, 0, 0);
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    check("frz.resume.x", topLeftX, 308);
    check("frz.resume.frozen", frozen, 0);
    $display("freeze: resumed x=%0d frozen=%0d", topLeftX, frozen);

    // Hit coincident with startOfFrame
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
    check("coinc.frozen", frozen, 1);
    check("coinc.x", topLeftX, 304);
    $display("coincident: x=%0d frozen=%0d", topLeftX, frozen);

    // Frozen sprite drawing (blinks only with the optional feature)
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    fc = 0;
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < 2; k++) begin
        bl = 1'b0;
`ifdef PLAYER_BLINK_EN
        bl = ((fc >> 3) & 1) == 1;
`endif
        cycle((k == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b0, 310, 425);
        check("blink.inside", InsideRectangle, bl ? 0 : 1);
        check("blink.offX", offsetX, bl ? 0 : 6);
        check("blink.offY", offsetY, bl ? 0 : 5);
        if (k == 0) fc++;
      end
    end
    $display("blink: 40 frames checked");

    // Asynchronous reset in mid-frame
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 310, 425);
    check("mid.pre.offX", offsetX, 2);
    #3;
    reset = 1'b1;
    #1;
    check("mid.x", topLeftX, 304);
    check("mid.frozen", frozen, 0);
    check("mid.inside", InsideRectangle, 0);
    check("mid.offX", offsetX, 0);
    check("mid.offY", offsetY, 0);
    reset = 1'b0;
    model_reset();
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    check("mid.resume.x", topLeftX, 308);
    $display("midreset: resumed x=%0d", topLeftX);

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        px = m_x + int'($urandom_range(0, 40)) - 4;
        if (px < 0) px = 0;
        py = int'($urandom_range(410, 445));
      end else begin
        px = int'($urandom_range(0, 2047));
        py = int'($urandom_range(0, 2047));
      end
      cycle(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0, px, py);
      chk_model("rnd");
    end
    $display("random: 4000 cycles, final x=%0d frozen=%0d", topLeftX, frozen);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
